// File: rtl/descriptor_distance.sv
// SAD engine: buffers one query descriptor, streams scene descriptors from RAM and
// emits one saturating (distance, index) pair per scene feature in ascending order.
module descriptor_distance #(
  parameter  int unsigned DIM      = 128,
  parameter  int unsigned EW       = 8,
  parameter  int unsigned DW       = 17,
  parameter  int unsigned MAX_FEAT = 1024,
  localparam int unsigned IW       = $clog2(MAX_FEAT),
  localparam int unsigned EL       = $clog2(DIM),
  localparam int unsigned AW       = IW + EL
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          i_start,
  input  logic [IW:0]   i_fnum_scene,
  input  logic          i_q_valid,
  input  logic [EW-1:0] i_q_data,
  output logic          o_q_ready,
  output logic [AW-1:0] o_s_addr,
  input  logic [EW-1:0] i_s_data,
  input  logic          i_stall,
  output logic [DW-1:0] o_diff,
  output logic [IW-1:0] o_indx_s,
  output logic          o_diff_valid,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [EL-1:0] ELEM_LAST = EL'(DIM - 1);
  localparam logic [IW:0]   N_MAX     = (IW + 1)'(MAX_FEAT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  logic [EL-1:0] elem;
  logic [IW-1:0] idx;
  logic [IW:0]   n_lat;
  logic          a0_valid;

  logic          p1_valid;
  logic [IW-1:0] p1_idx;
  logic [EL-1:0] p1_elem;
  logic          p2_valid;
  logic [IW-1:0] p2_idx;
  logic [EL-1:0] p2_elem;
  logic [EW-1:0] diff_r;
  logic [DW-1:0] acc;

  logic [EW-1:0] qbuf [DIM];
  logic [EW-1:0] q_sel;
  logic [EW-1:0] abs_diff;
  logic [DW:0]   acc_base;
  logic [DW:0]   acc_sum;
  logic [DW-1:0] acc_sat;
  logic [IW:0]   n_clamp;
  logic          last_feat;
  logic          q_hs;

  assign q_hs      = (state == LOAD) && i_q_valid;
  assign n_clamp   = (i_fnum_scene > N_MAX) ? N_MAX : i_fnum_scene;
  assign last_feat = ({1'b0, idx} == (n_lat - 1'b1));
  assign q_sel     = qbuf[p1_elem];

  always_comb begin
    abs_diff = (q_sel >= i_s_data) ? (q_sel - i_s_data) : (i_s_data - q_sel);
    acc_base = (p2_elem == '0) ? '0 : {1'b0, acc};
    acc_sum  = acc_base + {{(DW + 1 - EW){1'b0}}, diff_r};
    acc_sat  = acc_sum[DW] ? '1 : acc_sum[DW-1:0];
  end

  // Query buffer is always fully reloaded before use, so it carries no reset.
  always_ff @(posedge iclk) begin
    if (q_hs) qbuf[elem] <= i_q_data;
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state     <= IDLE;
      elem      <= '0;
      idx       <= '0;
      n_lat     <= '0;
      a0_valid  <= 1'b0;
      o_s_addr  <= '0;
      o_q_ready <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      a0_valid <= 1'b0;
      o_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state     <= LOAD;
            n_lat     <= n_clamp;
            elem      <= '0;
            idx       <= '0;
            o_q_ready <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (i_q_valid) begin
            if (elem == ELEM_LAST) begin
              elem      <= '0;
              o_q_ready <= 1'b0;
              if (n_lat == '0) begin
                state  <= DONE;
                o_done <= 1'b1;
              end else begin
                state <= RUN;
              end
            end else begin
              elem <= elem + 1'b1;
            end
          end
        end
        RUN: begin
          // Stall only gates the first element of a feature, so features are never split.
          if (!((elem == '0) && i_stall)) begin
            o_s_addr <= {idx, elem};
            a0_valid <= 1'b1;
            if (elem == ELEM_LAST) begin
              elem <= '0;
              if (last_feat) state <= DRAIN;
              else           idx   <= idx + 1'b1;
            end else begin
              elem <= elem + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!a0_valid && !p1_valid && !p2_valid) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Element tag travels alongside the RAM latency; p1 lines up with i_s_data.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      p1_valid     <= 1'b0;
      p1_idx       <= '0;
      p1_elem      <= '0;
      p2_valid     <= 1'b0;
      p2_idx       <= '0;
      p2_elem      <= '0;
      diff_r       <= '0;
      acc          <= '0;
      o_diff       <= '0;
      o_indx_s     <= '0;
      o_diff_valid <= 1'b0;
    end else begin
      p1_valid     <= a0_valid;
      p1_idx       <= o_s_addr[AW-1:EL];
      p1_elem      <= o_s_addr[EL-1:0];
      p2_valid     <= p1_valid;
      p2_idx       <= p1_idx;
      p2_elem      <= p1_elem;
      diff_r       <= abs_diff;
      o_diff_valid <= 1'b0;
      if (p2_valid) begin
        acc <= acc_sat;
        if (p2_elem == ELEM_LAST) begin
          o_diff       <= acc_sat;
          o_indx_s     <= p2_idx;
          o_diff_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_descriptor_distance.sv
// Directed bench for descriptor_distance: table of query/scene cases plus reset,
// saturation (DIM=1024) and feature-count clamp (DIM=4) sequences.
module tb_descriptor_distance;

  localparam int D = 128;

  logic        iclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] fnum = '0;
  logic        q_valid = 1'b0;
  logic [7:0]  q_data = '0;
  logic        q_ready;
  logic [16:0] s_addr;
  logic [7:0]  s_data = '0;
  logic        stall = 1'b0;
  logic [16:0] diff;
  logic [9:0]  indx;
  logic        dvalid, busy, done;

  logic        b_start = 1'b0, b_qv = 1'b0, b_ready, b_dv, b_busy, b_done;
  logic [10:0] b_fnum = '0;
  logic [7:0]  b_qdata = 8'd255, b_sdata = 8'd0;
  logic [19:0] b_saddr;
  logic [16:0] b_diff;
  logic [9:0]  b_idx;

  logic        c_start = 1'b0, c_qv = 1'b0, c_ready, c_dv, c_busy, c_done;
  logic [10:0] c_fnum = '0;
  logic [7:0]  c_qdata = 8'd0, c_sdata = 8'd3;
  logic [11:0] c_saddr;
  logic [16:0] c_diff;
  logic [9:0]  c_idx;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  descriptor_distance u_dut (
    .iclk(iclk), .irst(rst_n), .i_start(start), .i_fnum_scene(fnum),
    .i_q_valid(q_valid), .i_q_data(q_data), .o_q_ready(q_ready),
    .o_s_addr(s_addr), .i_s_data(s_data), .i_stall(stall),
    .o_diff(diff), .o_indx_s(indx), .o_diff_valid(dvalid),
    .o_busy(busy), .o_done(done)
  );

  descriptor_distance #(.DIM(1024)) u_sat (
    .iclk(iclk), .irst(rst_n), .i_start(b_start), .i_fnum_scene(b_fnum),
    .i_q_valid(b_qv), .i_q_data(b_qdata), .o_q_ready(b_ready),
    .o_s_addr(b_saddr), .i_s_data(b_sdata), .i_stall(1'b0),
    .o_diff(b_diff), .o_indx_s(b_idx), .o_diff_valid(b_dv),
    .o_busy(b_busy), .o_done(b_done)
  );

  descriptor_distance #(.DIM(4)) u_clamp (
    .iclk(iclk), .irst(rst_n), .i_start(c_start), .i_fnum_scene(c_fnum),
    .i_q_valid(c_qv), .i_q_data(c_qdata), .o_q_ready(c_ready),
    .o_s_addr(c_saddr), .i_s_data(c_sdata), .i_stall(1'b0),
    .o_diff(c_diff), .o_indx_s(c_idx), .o_diff_valid(c_dv),
    .o_busy(c_busy), .o_done(c_done)
  );

  // Scene RAM model: features 0..3 are constant or ramp, higher features read 0.
  logic [3:0][7:0] cur_fv = '0;
  logic [3:0]      cur_ramp = '0;

  function automatic logic [7:0] scene_byte(input logic [16:0] a);
    logic [9:0] fi;
    fi = a[16:7];
    if (fi > 10'd3) return 8'd0;
    if (cur_ramp[fi[1:0]]) return {1'b0, a[6:0]};
    return cur_fv[fi[1:0]];
  endfunction

  always @(posedge iclk) s_data <= scene_byte(s_addr);

  int sq_diff[$], sq_idx[$], sq_cyc[$], dq_cyc[$], aq[$], acq[$];
  int coinc = 0;
  logic [16:0] prev_addr = '0;

  always @(negedge iclk) begin
    if (dvalid) begin
      sq_diff.push_back(int'(diff));
      sq_idx.push_back(int'(indx));
      sq_cyc.push_back(cyc);
    end
    if (done) dq_cyc.push_back(cyc);
    if (dvalid && done) coinc++;
    if (s_addr != prev_addr) begin
      aq.push_back(int'(s_addr));
      acq.push_back(cyc);
    end
    prev_addr = s_addr;
  end

  int c_cnt = 0, c_bad = 0, c_last = -1;
  always @(negedge iclk) begin
    if (c_dv) begin
      if (c_idx != 10'(c_cnt) || c_diff != 17'd12) c_bad++;
      c_last = int'(c_idx);
      c_cnt++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [10:0]      n;
    logic [7:0]       qv;
    logic             qramp;
    logic [3:0][7:0]  fv;
    logic [3:0]       ramp;
    logic             stl;
    logic [3:0][16:0] ex;
  } vec_t;

  function automatic vec_t mk(input int n, input int qv, input bit qr,
                              input int f0, input int f1, input int f2, input int f3,
                              input bit [3:0] rm, input bit st,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.n = 11'(n); v.qv = 8'(qv); v.qramp = qr;
    v.fv = {8'(f3), 8'(f2), 8'(f1), 8'(f0)};
    v.ramp = rm; v.stl = st;
    v.ex = {17'(e3), 17'(e2), 17'(e1), 17'(e0)};
    return v;
  endfunction

  // Loads D query elements with one bubble; a stray i_start mid-load must be ignored.
  task automatic load_query(input int n, input int qv, input bit qr, output int h, output int loaded);
    int g;
    loaded = 0; g = 0; h = 0;
    @(negedge iclk); fnum = 11'(n); start = 1'b1;
    while (loaded < D && g < 300) begin
      @(negedge iclk); g++;
      fnum = 11'h7ff;
      if (g == 6) begin
        q_valid = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
        if (q_ready) begin
          q_valid = 1'b1;
          q_data = qr ? 8'(loaded) : 8'(qv);
          if (loaded == D - 1) h = cyc + 1;
          loaded++;
        end else begin
          q_valid = 1'b0;
        end
      end
    end
    @(negedge iclk); q_valid = 1'b0; start = 1'b0;
  endtask

  task automatic run_query(input vec_t v);
    int s0, d0, a0, h, ld, ne, k, st_on, st_off, last, j;
    chk("idle_before", busy, 0);
    s0 = sq_diff.size(); d0 = dq_cyc.size(); a0 = aq.size();
    cur_fv = v.fv; cur_ramp = v.ramp;
    load_query(int'(v.n), int'(v.qv), v.qramp, h, ld);
    chk("load_count", ld, D);
    ne = (v.n > 11'd1024) ? 1024 : int'(v.n);
    st_on = h + 2 * D + 1 - 9;
    st_off = h + 2 * D + 1 + 19;
    k = 0;
    while (dq_cyc.size() == d0 && k < ne * D + 300) begin
      @(negedge iclk); k++;
      start = (k == 50);
      if (v.stl && cyc == st_on) stall = 1'b1;
      if (v.stl && cyc == st_off) stall = 1'b0;
    end
    start = 1'b0; stall = 1'b0;
    @(negedge iclk); @(negedge iclk);
    chk("done_count", dq_cyc.size() - d0, 1);
    chk("busy_after", busy, 0);
    chk("strobe_count", sq_diff.size() - s0, ne);
    for (int i = 0; i < ne && s0 + i < sq_diff.size(); i++) begin
      chk($sformatf("diff_f%0d", i), sq_diff[s0 + i], longint'(v.ex[i]));
      chk($sformatf("indx_f%0d", i), sq_idx[s0 + i], i);
      if (i == 0) chk("first_latency", sq_cyc[s0] - h, D + 3);
      else chk($sformatf("spacing_f%0d", i), sq_cyc[s0 + i] - sq_cyc[s0 + i - 1],
               D + ((v.stl && i == 2) ? 20 : 0));
    end
    if (dq_cyc.size() > d0) begin
      last = (ne > 0 && sq_diff.size() > s0) ? sq_cyc[sq_diff.size() - 1] : h - 1;
      chk("done_timing", dq_cyc[d0], last + 1);
    end
    if (v.stl) begin
      j = -1;
      for (int i = a0 + 1; i < aq.size(); i++) if (aq[i] == 2 * D && j < 0) j = i;
      chk("stall_resume_found", (j > 0) ? 1 : 0, 1);
      if (j > 0) begin
        chk("stall_prev_addr", aq[j - 1], 2 * D - 1);
        chk("stall_addr_gap", acq[j] - acq[j - 1], 21);
      end
    end
  endtask

  initial begin
    vec_t vt[7];
    int h, ld, g, s0, d0;
    vt[0] = mk(3, 10, 0, 10, 12, 0, 0, 4'b0000, 0, 0, 256, 1280, 0);
    vt[1] = mk(4, 10, 0, 10, 12, 0, 0, 4'b1000, 0, 0, 256, 1280, 6958);
    vt[2] = mk(3, 200, 0, 0, 255, 200, 0, 4'b0000, 1, 25600, 7040, 0, 0);
    vt[3] = mk(0, 7, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    vt[4] = mk(1, 255, 0, 0, 0, 0, 0, 4'b0000, 0, 32640, 0, 0, 0);
    vt[5] = mk(2, 0, 1, 0, 0, 0, 0, 4'b0010, 0, 8128, 0, 0, 0);
    vt[6] = mk(2, 10, 0, 10, 12, 0, 0, 4'b0000, 0, 0, 256, 0, 0);

    @(negedge iclk);
    chk("rst_diff", diff, 0);
    chk("rst_indx", indx, 0);
    chk("rst_valid", dvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q_ready", q_ready, 0);
    chk("rst_s_addr", s_addr, 0);
    @(negedge iclk); rst_n = 1'b1;
    @(negedge iclk);

    for (int i = 0; i < 6; i++) run_query(vt[i]);

    // Abort during feature 5, then restart.
    cur_fv = vt[0].fv; cur_ramp = '0;
    s0 = sq_diff.size(); d0 = dq_cyc.size();
    load_query(8, 10, 0, h, ld);
    g = 0;
    while (s_addr != 17'(5 * D + 10) && g < 2000) begin
      @(negedge iclk); g++;
    end
    chk("reached_f5", s_addr, 5 * D + 10);
    rst_n = 1'b0;
    #1;
    chk("abort_diff", diff, 0);
    chk("abort_indx", indx, 0);
    chk("abort_busy", busy, 0);
    chk("abort_s_addr", s_addr, 0);
    chk("abort_q_ready", q_ready, 0);
    repeat (3) @(negedge iclk);
    rst_n = 1'b1;
    repeat (3) @(negedge iclk);
    chk("abort_strobes", sq_diff.size() - s0, 5);
    if (sq_diff.size() - s0 == 5) chk("abort_f4_diff", sq_diff[s0 + 4], 1280);
    chk("abort_no_done", dq_cyc.size() - d0, 0);
    chk("abort_valid_low", dvalid, 0);
    run_query(vt[6]);
    chk("no_strobe_done_overlap", coinc, 0);

    // DIM=1024: 1024*255 overflows 17 bits and must saturate.
    @(negedge iclk); b_fnum = 11'd1; b_start = 1'b1;
    @(negedge iclk); b_start = 1'b0;
    ld = 0; g = 0;
    while (ld < 1024 && g < 1200) begin
      if (b_ready) begin b_qv = 1'b1; ld++; end
      else b_qv = 1'b0;
      @(negedge iclk); g++;
    end
    b_qv = 1'b0;
    g = 0;
    while (!b_dv && g < 1300) begin
      @(negedge iclk); g++;
    end
    chk("sat_strobe_seen", b_dv, 1);
    chk("sat_diff", b_diff, 131071);
    chk("sat_indx", b_idx, 0);
    @(negedge iclk);
    chk("sat_done", b_done, 1);

    // DIM=4: N=2000 is clamped to 1024 features.
    @(negedge iclk); c_fnum = 11'd2000; c_start = 1'b1;
    @(negedge iclk); c_start = 1'b0;
    ld = 0; g = 0;
    while (ld < 4 && g < 50) begin
      if (c_ready) begin c_qv = 1'b1; ld++; end
      else c_qv = 1'b0;
      @(negedge iclk); g++;
    end
    c_qv = 1'b0;
    g = 0;
    while (!c_done && g < 5000) begin
      @(negedge iclk); g++;
    end
    chk("clamp_done_seen", c_done, 1);
    chk("clamp_count", c_cnt, 1024);
    chk("clamp_last_idx", c_last, 1023);
    chk("clamp_bad", c_bad, 0);
    @(negedge iclk); @(negedge iclk);
    chk("clamp_busy_after", c_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
